prom_shadow_loader: RTL and testbench

//  Read-side initiator for the small bipolar PROMs (7112-class, 32x8, async read).

---
 rtl/prom_shadow_loader.sv | 102 ++++++++++
 tb/tb_prom_shadow_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/prom_shadow_loader.sv
// prom_shadow_loader: walks an async PROM once per START and streams each byte as a one-cycle shadow-RAM write.
// Optional running byte checksum output is enabled by defining PROM_LOADER_CHECKSUM_EN.
module prom_shadow_loader #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  prom_e_n_o,
    output logic [ADDR_WIDTH-1:0] prom_a_o,
    input  logic [DATA_WIDTH-1:0] prom_q_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o
`ifdef PROM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum_o
`endif
);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, FINISH, DONE_S} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  busy_q, done_q, e_n_q, wr_en_q;
    logic [ADDR_WIDTH-1:0] prom_a_q, wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
`ifdef PROM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;
    assign checksum_o = sum_q;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            e_n_q     <= 1'b1;
            prom_a_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef PROM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE, DONE_S: if (start_i) begin
                    state_q  <= ACCESS;
                    prom_a_q <= '0;
                    e_n_q    <= 1'b0;
                    busy_q   <= 1'b1;
                    done_q   <= 1'b0;
                    cnt_q    <= RELOAD;
`ifdef PROM_LOADER_CHECKSUM_EN
                    sum_q    <= '0;
`endif
                end
                ACCESS: if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    // capture edge: Q has been stable for WAIT_CYCLES clocks
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= prom_a_q;
                    wr_data_q <= prom_q_i;
`ifdef PROM_LOADER_CHECKSUM_EN
                    sum_q     <= sum_q + prom_q_i;
`endif
                    if (&prom_a_q) begin
                        state_q <= FINISH;
                        e_n_q   <= 1'b1;
                    end else begin
                        prom_a_q <= prom_a_q + 1'b1;
                        cnt_q    <= RELOAD;
                    end
                end
                FINISH: begin
                    state_q <= DONE_S;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign prom_e_n_o = e_n_q;
    assign prom_a_o   = prom_a_q;
    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
endmodule

// File: tb/tb_prom_shadow_loader.sv
// tb_prom_shadow_loader: directed/random loads of a 32x8 PROM model, checked against the expected write stream.
// Covers default and WAIT_CYCLES=4 (35 ns tAA model) instances; checksum checks when PROM_LOADER_CHECKSUM_EN is defined.
module tb_prom_shadow_loader;
    logic       clk = 1'b0, rst_n = 1'b1, start2 = 1'b0, start4 = 1'b0;
    logic       b2, d2, e2, w2, b4, d4, e4, w4;
    logic [4:0] a2, wa2, a4, wa4;
    logic [7:0] wd2, wd4, q4;
    logic [7:0] mem [32];
    int         mem_gen = 0;
    int         errors = 0, checks = 0;
    bit         sel = 1'b0;
`ifdef PROM_LOADER_CHECKSUM_EN
    logic [7:0] cs2, cs4;
`endif

    prom_shadow_loader dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .busy_o(b2), .done_o(d2),
        .prom_e_n_o(e2), .prom_a_o(a2), .prom_q_i(mem[a2]), .wr_en_o(w2),
        .wr_addr_o(wa2), .wr_data_o(wd2)
`ifdef PROM_LOADER_CHECKSUM_EN
        , .checksum_o(cs2)
`endif
    );

    prom_shadow_loader #(.WAIT_CYCLES(4)) u4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start4), .busy_o(b4), .done_o(d4),
        .prom_e_n_o(e4), .prom_a_o(a4), .prom_q_i(q4), .wr_en_o(w4),
        .wr_addr_o(wa4), .wr_data_o(wd4)
`ifdef PROM_LOADER_CHECKSUM_EN
        , .checksum_o(cs4)
`endif
    );

    // PROM with 35 ns address access time: Q is unknown until tAA after any address change
    always @(a4 or mem_gen) begin
        q4 = 'x;
        #35 q4 = mem[a4];
    end

    initial begin
        #20;
        forever #5 clk = ~clk;
    end

    wire       m_busy = sel ? b4 : b2;
    wire       m_done = sel ? d4 : d2;
    wire       m_en_n = sel ? e4 : e2;
    wire [4:0] m_a    = sel ? a4 : a2;
    wire       m_wen  = sel ? w4 : w2;
    wire [4:0] m_wa   = sel ? wa4 : wa2;
    wire [7:0] m_wd   = sel ? wd4 : wd2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_busy", b2, 0);
        chk("rst_done", d2, 0);
        chk("rst_e_n", e2, 1);
        chk("rst_a", a2, 0);
        chk("rst_wen", w2, 0);
        chk("rst_waddr", wa2, 0);
        chk("rst_wdata", wd2, 0);
        chk("rst4_e_n", e4, 1);
`ifdef PROM_LOADER_CHECKSUM_EN
        chk("rst_cs", cs2, 0);
`endif
    endtask

    // One load: the expected stream is mem[0..31] in address order, done after 32*W+1 edges
    task automatic run_load(input bit s, input int hold_lo, input int hold_hi, input int abort_at);
        int         w, last, n;
        logic [4:0] pa;
        logic [7:0] sum;
        w = s ? 4 : 2;
        last = 32 * w + 1;
        n = 0;
        sum = '0;
        foreach (mem[i]) sum += mem[i];
        sel = s;
        @(negedge clk);
        if (s) start4 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        start4 = 1'b0;
        chk("start_busy", m_busy, 1);
        chk("start_done", m_done, 0);
        chk("start_e_n", m_en_n, 0);
        chk("start_a", m_a, 0);
`ifdef PROM_LOADER_CHECKSUM_EN
        if (!s) chk("start_cs", cs2, 0);
`endif
        pa = m_a;
        for (int k = 1; k <= last; k++) begin
            if (!s) start2 = (k >= hold_lo && k <= hold_hi);
            @(posedge clk);
            #1;
            if (m_wen) begin
                chk("wr_addr", m_wa, n);
                chk("wr_data", m_wd, mem[n[4:0]]);
                n++;
            end
            if (m_a !== pa) chk("a_step_edge", k % w, 0);
            pa = m_a;
            if (abort_at > 0 && n == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (k == last - 1) begin
                chk("pre_done", m_done, 0);
                chk("pre_busy", m_busy, 1);
                chk("last_wen", m_wen, 1);
            end
        end
        start2 = 1'b0;
        chk("n_writes", n, 32);
        chk("done", m_done, 1);
        chk("busy", m_busy, 0);
        chk("e_n", m_en_n, 1);
        chk("a_hold", m_a, 31);
        chk("wen_off", m_wen, 0);
        chk("waddr_hold", m_wa, 31);
        chk("wdata_hold", m_wd, mem[31]);
`ifdef PROM_LOADER_CHECKSUM_EN
        chk("checksum", s ? cs4 : cs2, sum);
`endif
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'(3 * i);
        #1 rst_n = 1'b0;
        #9;
        chk_reset();
        #5 rst_n = 1'b1;
        // plain load with byte[a] = 3a
        run_load(0, 0, -1, 0);
        // random contents, START held high across edges 10..20 of the load
        foreach (mem[i]) mem[i] = 8'($urandom);
        mem_gen++;
        run_load(0, 10, 20, 0);
        // reset after the 10th write, then a complete reload from address 0
        foreach (mem[i]) mem[i] = 8'($urandom);
        mem_gen++;
        run_load(0, 0, -1, 10);
        chk("post_abort_done", d2, 0);
        run_load(0, 0, -1, 0);
        // slow PROM: four clocks per byte
        foreach (mem[i]) mem[i] = 8'($urandom);
        mem_gen++;
        run_load(1, 0, -1, 0);
`ifdef PROM_LOADER_CHECKSUM_EN
        foreach (mem[i]) mem[i] = 8'hFF;
        mem_gen++;
        run_load(0, 0, -1, 0);
        chk("cs_ff", cs2, 8'hE0);
        run_load(0, 0, -1, 0);
        chk("cs_ff_reload", cs2, 8'hE0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
